// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared stream helpers: lane counts, popcount, saturating add, beat record
package axis_pkg;

  localparam int unsigned AXIS_DEF_DW    = 32;
  localparam int unsigned AXIS_DEF_LANES = AXIS_DEF_DW / 8;
  // Widest lane mask the popcount helper handles (512-bit TDATA)
  localparam int unsigned AXIS_MAX_LANES = 64;

  // Beat record at the default width; parameterised blocks declare their own copy
  typedef struct packed {
    logic [AXIS_DEF_DW-1:0]    data;
    logic [AXIS_DEF_LANES-1:0] keep;
    logic                      last;
  } axis_beat_t;

  // Byte-lane count for a TDATA width in bits
  function automatic int unsigned axis_lanes(input int unsigned dw);
    return dw / 8;
  endfunction

  // Number of set lanes in a (zero-extended) lane mask
  function automatic logic [7:0] popcount(input logic [AXIS_MAX_LANES-1:0] mask);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < int'(AXIS_MAX_LANES); i++) begin
      n = n + {7'd0, mask[i]};
    end
    return n;
  endfunction

  // Saturating add at 2**width-1; returns {overflowed, result}
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    if (s > lim) begin
      return {1'b1, lim[31:0]};
    end
    return {1'b0, s[31:0]};
  endfunction

endpackage

// File: rtl/axis_slave_rx_sfifo.sv
// rtl/axis_slave_rx_sfifo.sv - synchronous FIFO with a registered output stage
module sfifo #(
  parameter int WIDTH  = 8,
  parameter int LGFIFO = 4
) (
  input  logic              i_aclk,
  input  logic              i_areset,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ready,
  output logic              empty,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic [LGFIFO:0]   fill
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0] FULL_LVL = {1'b1, {LGFIFO{1'b0}}};

  // The output register counts as one slot, so the array never holds more
  // than DEPTH-1 entries and LGFIFO-bit pointers cannot alias.
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr;
  logic [LGFIFO-1:0] rd_ptr;
  logic              valid;
  logic              mem_empty;
  logic              pop;
  logic              load;
  logic              from_mem;
  logic              bypass;
  logic              mem_wr;
  logic [LGFIFO:0]   fill_next;

  assign empty     = !valid;
  assign mem_empty = (wr_ptr == rd_ptr);
  assign pop       = valid && ready;
  assign load      = !valid || pop;
  assign from_mem  = load && !mem_empty;
  assign bypass    = load && mem_empty && push;
  assign mem_wr    = push && !bypass;

  // Occupancy moves only when exactly one of push/pop happens
  always_comb begin
    fill_next = fill;
    if (push && !pop) begin
      fill_next = fill + (LGFIFO+1)'(1);
    end else if (!push && pop) begin
      fill_next = fill - (LGFIFO+1)'(1);
    end
  end

  // Storage array write; contents are don't-care after reset
  always_ff @(posedge i_aclk) begin
    if (mem_wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, output register, fill level and registered full flag
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
      fill   <= '0;
      full   <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= wr_ptr + LGFIFO'(1);
      end
      if (from_mem) begin
        rd_ptr <= rd_ptr + LGFIFO'(1);
      end
      if (load) begin
        valid <= from_mem || push;
        if (from_mem) begin
          rdata <= mem[rd_ptr];
        end else if (push) begin
          rdata <= wdata;
        end
      end
      fill <= fill_next;
      full <= (fill_next == FULL_LVL);
    end
  end

endmodule

// File: rtl/axis_slave_rx.sv
// rtl/axis_slave_rx.sv - AXI-Stream sink with beat FIFO and per-packet length/status records
module axis_slave_rx #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int LGFIFO            = 4,
  parameter int F_LGDEPTH         = 16,
  parameter int MAX_PACKET        = 0
) (
  input  logic                           i_aclk,
  input  logic                           i_areset,
  input  logic                           i_tvalid,
  output logic                           o_tready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   i_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] i_tstrb,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] i_tkeep,
  input  logic                           i_tlast,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [C_AXIS_DATA_WIDTH-1:0]   o_data,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] o_keep,
  output logic                           o_last,
  output logic                           o_pkt_valid,
  output logic [F_LGDEPTH-1:0]           o_pkt_len,
  output logic                           o_pkt_overlong,
  output logic                           o_proto_err,
  output logic [LGFIFO:0]                o_fill
);

  import axis_pkg::*;

  localparam int unsigned NL = axis_lanes(C_AXIS_DATA_WIDTH);
  localparam int unsigned BW = C_AXIS_DATA_WIDTH + NL + 1;

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0] data;
    logic [NL-1:0]                keep;
    logic                         last;
  } beat_t;

  beat_t                wr_beat;
  beat_t                rd_beat;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 accept;
  logic [NL-1:0]        lane_mask;
  logic [7:0]           vbytes;
  logic [32:0]          sat_res;
  logic [F_LGDEPTH-1:0] sum;
  logic                 sum_ovf;
  logic                 too_long;
  logic                 reserved;
  logic                 unused_sat_hi;

  // Packet state: running byte count and a sticky saturation flag
  logic [F_LGDEPTH-1:0] cnt;
  logic                 r_ovl;

  assign o_tready  = !fifo_full && !i_areset;
  assign accept    = i_tvalid && o_tready;
  assign lane_mask = i_tkeep & i_tstrb;
  assign reserved  = i_tvalid && (|(~i_tkeep & i_tstrb));

  assign wr_beat = '{data: i_tdata, keep: lane_mask, last: i_tlast};

  sfifo #(
    .WIDTH  (BW),
    .LGFIFO (LGFIFO)
  ) u_fifo (
    .i_aclk   (i_aclk),
    .i_areset (i_areset),
    .push     (accept),
    .wdata    (wr_beat),
    .ready    (i_ready),
    .empty    (fifo_empty),
    .rdata    (rd_beat),
    .full     (fifo_full),
    .fill     (o_fill)
  );

  assign o_valid = !fifo_empty;
  assign o_data  = rd_beat.data;
  assign o_keep  = rd_beat.keep;
  assign o_last  = rd_beat.last;

  assign vbytes        = popcount(AXIS_MAX_LANES'(lane_mask));
  assign sat_res       = sat_add(32'(cnt), 32'(vbytes), F_LGDEPTH);
  assign sum           = sat_res[F_LGDEPTH-1:0];
  assign sum_ovf       = sat_res[32];
  assign unused_sat_hi = ^sat_res[31:F_LGDEPTH];
  assign too_long      = (MAX_PACKET > 0) && (32'(sum) > 32'(MAX_PACKET));

  // Byte accounting; the record goes out as the tlast beat is accepted
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      cnt            <= '0;
      r_ovl          <= 1'b0;
      o_pkt_valid    <= 1'b0;
      o_pkt_len      <= '0;
      o_pkt_overlong <= 1'b0;
    end else begin
      o_pkt_valid <= accept && i_tlast;
      if (accept) begin
        if (i_tlast) begin
          o_pkt_len      <= sum;
          o_pkt_overlong <= r_ovl || sum_ovf || too_long;
          cnt            <= '0;
          r_ovl          <= 1'b0;
        end else begin
          cnt   <= sum;
          r_ovl <= r_ovl || sum_ovf;
        end
      end
    end
  end

  // Sticky flag for strobed bytes that keep marks as absent
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      o_proto_err <= 1'b0;
    end else if (reserved) begin
      o_proto_err <= 1'b1;
    end
  end

endmodule

// File: doc/axis_slave_rx.md
Name: axis_slave_rx

Overview:
- AXI-Stream slave (receiving end) that accepts beats from any compliant stream master and buffers them in a synchronous FIFO.
- Presents buffered beats on a simple valid/ready read port.
- Emits one length/status record per completed packet.
- Flags reserved TKEEP/TSTRB encodings and overlong packets.
- Sits at the sink end of stream pipelines, e.g. ahead of DMA writers or packet processors.

Parameters:
- C_AXIS_DATA_WIDTH, 32, TDATA width in bits; multiple of 8, at least 8.
- LGFIFO, 4, log2 of FIFO depth in beats; depth = 2**LGFIFO.
- F_LGDEPTH, 16, width of packet byte-length counter.
- MAX_PACKET, 0, maximum legal packet length in bytes; 0 disables the check.

Ports:
- i_aclk  in  1  clock; all logic rising-edge.
- i_areset  in  1  asynchronous, active-high reset.
- i_tvalid  in  1  stream beat valid.
- o_tready  out  1  slave ready.
- i_tdata  in  DW  stream data.
- i_tstrb  in  DW/8  byte strobes.
- i_tkeep  in  DW/8  byte keep.
- i_tlast  in  1  last beat of packet.
- o_valid  out  1  read-port beat valid.
- i_ready  in  1  read-port consumer ready.
- o_data  out  DW  buffered data.
- o_keep  out  DW/8  buffered (tkeep & tstrb) byte mask.
- o_last  out  1  buffered tlast.
- o_pkt_valid  out  1  single-cycle pulse: packet record valid.
- o_pkt_len  out  F_LGDEPTH  byte count of completed packet.
- o_pkt_overlong  out  1  completed packet exceeded MAX_PACKET or saturated the counter.
- o_proto_err  out  1  sticky: reserved encoding seen.
- o_fill  out  LGFIFO+1  current FIFO occupancy.

Behaviour:
- Reset: while i_areset is high (asynchronous assert, synchronous release on i_aclk) these outputs are 0: o_tready, o_valid, o_data, o_keep, o_last, o_pkt_valid, o_pkt_len, o_pkt_overlong, o_proto_err, o_fill. FIFO pointers and the byte counter clear. A reset in mid-packet discards the partial packet and emits no record.
- o_tready = !r_full && !reset, where r_full is registered. First acceptance is possible on the first clock edge after reset release.
- Accept = i_tvalid && o_tready. On accept, {tdata, tkeep&tstrb, tlast} is written to the FIFO.
- No write-through when full: a pop in the same cycle frees space for the next cycle only.
- Read port is registered FIFO output. Latency from accept edge to o_valid high is 1 cycle when the FIFO was empty.
- Pop = o_valid && i_ready. o_data, o_keep and o_last are held stable while o_valid && !i_ready.
- Simultaneous push and pop with the FIFO neither empty nor full: occupancy unchanged, order preserved.
- o_fill range is 0..2**LGFIFO. It increments on push-only, decrements on pop-only, and is unchanged on both or neither.
- Byte counting: vbytes = popcount(tkeep & tstrb) of the accepted beat. Null beats (vbytes = 0) are legal and count 0.
- Byte counter:
  - Accept with !tlast: cnt <= sat(cnt + vbytes). Saturation is at 2**F_LGDEPTH-1 and sets r_ovl.
  - Accept with tlast: o_pkt_len <= sat(cnt + vbytes), o_pkt_valid <= 1 for 1 cycle, o_pkt_overlong <= r_ovl || sat-overflow || (MAX_PACKET>0 && total > MAX_PACKET). Then cnt <= 0 and r_ovl <= 0.
- The record is emitted on accept, independent of read-port drain. Back-to-back tlast beats give consecutive pulses.
- Protocol check: if i_tvalid && (~tkeep & tstrb) != 0, o_proto_err is set 1 cycle later and held until reset. The beat is still accepted if tready is high, with the reserved bytes masked out by keep&strb.
- No state machine beyond the FIFO; packet state is {cnt, r_ovl}.

Decomposition:
- Shared package axis_pkg:
  - localparam byte-lane count DW/8.
  - popcount function for lane masks.
  - saturating-add helper.
  - beat record typedef {data, keep, last}.
- One sub-module, sfifo: a synchronous FIFO with parameters width and LGFIFO, providing push/pop, full/empty and fill outputs, and a registered output.
- Packet accounting stays in axis_slave_rx.

Test Plan:
- Reset release, then 3-beat packet at DW=32, keep=strb=4'hF on all beats, last on beat 3 → o_pkt_valid pulse once with o_pkt_len=12, overlong=0. Read port returns the 3 beats in order, o_last on the third.
- Fill the FIFO: i_ready=0, 17 beats offered at LGFIFO=4 → o_tready drops after 16 accepts and o_fill=16. One pop → o_tready high the next cycle and the 17th beat is accepted.
- Partial and null beats: keep/strb = 4'h3, 4'h0, 4'h1 with last → o_pkt_len=3; o_keep read back = 3, 0, 1.
- MAX_PACKET=8: two full beats plus a last beat with keep=4'h1 → o_pkt_len=9, o_pkt_overlong=1. Next packet of 4 bytes → overlong=0.
- Reserved encoding: tvalid with tkeep=4'h0, tstrb=4'h1 → o_proto_err=1 the next cycle and stays high until i_areset.
- Reset asserted mid-packet after 2 beats → all outputs 0 immediately. Post-reset 1-beat packet with keep=4'hF and last → o_pkt_len=4.
